// File: rtl/debouncer_pkg.sv
// Shared limits for the debouncer slice: the smallest legal synchronizer depth
// and debounce count, plus a helper that checks both at elaboration.
package debouncer_pkg;

    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MIN_DEBOUNCE_CYCLES = 1;

    function automatic bit params_ok(input int sync_stages, input int debounce_cycles);
        return (sync_stages >= MIN_SYNC_STAGES) && (debounce_cycles >= MIN_DEBOUNCE_CYCLES);
    endfunction

endpackage

// File: rtl/debouncer_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level. Every flop resets
// to RESET_VALUE so the chain never emits a spurious edge out of reset.
module synchronizer
    import debouncer_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $error("synchronizer: STAGES must be >= %0d", MIN_SYNC_STAGES);
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) chain <= {STAGES{RESET_VALUE}};
        else         chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronizes a raw level, then accepts a new level only after
// DEBOUNCE_CYCLES consecutive identical synchronized samples.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic signal_in,
    output logic signal_out,
    output logic pending
);

    if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("debouncer: need SYNC_STAGES >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    localparam int   CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic ST_STABLE  = 1'b0;
    localparam logic ST_PENDING = 1'b1;
    // Counter value on the edge before acceptance; reaching DEBOUNCE_CYCLES toggles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        STABLE  = ST_STABLE,
        PENDING = ST_PENDING
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;

    synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (signal_in),
        .q      (s)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= STABLE;
            cnt        <= '0;
            signal_out <= RESET_VALUE;
            pending    <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (s != signal_out) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            signal_out <= ~signal_out;
                        end else begin
                            state   <= PENDING;
                            cnt     <= CNT_ONE;
                            pending <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (s == signal_out) begin
                        // Glitch: the candidate level vanished, start over.
                        state   <= STABLE;
                        cnt     <= '0;
                        pending <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        signal_out <= ~signal_out;
                        state      <= STABLE;
                        cnt        <= '0;
                        pending    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= STABLE;
                    cnt     <= '0;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer: stimulus queues the expected signal_out
// transitions (cycle, level); monitors pop them whenever an output changes.
module tb_debouncer;

    logic clock = 1'b0;
    logic resetn;
    logic in0, in1;
    logic out0, out1, pend0, pend1;

    always #5 clock = ~clock;

    debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b0)) dut (
        .clock(clock), .resetn(resetn), .signal_in(in0),
        .signal_out(out0), .pending(pend0)
    );

    debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(1'b0)) dut1 (
        .clock(clock), .resetn(resetn), .signal_in(in1),
        .signal_out(out1), .pending(pend1)
    );

    typedef struct {
        int   cyc;
        logic val;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        vectors = vectors + 1;
        if (act !== req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: every observed signal_out change must match the queue head.
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    always @(negedge clock) begin
        if (out0 !== prev0) begin
            if (q0.size() == 0) begin
                chk("dut_unexpected_toggle", int'(out0), int'(prev0));
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut_toggle_cycle", cyc, e.cyc);
                chk("dut_toggle_value", int'(out0), int'(e.val));
            end
            prev0 = out0;
        end
    end

    always @(negedge clock) begin
        if (out1 !== prev1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_toggle", int'(out1), int'(prev1));
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_toggle_cycle", cyc, e.cyc);
                chk("dut1_toggle_value", int'(out1), int'(e.val));
            end
            prev1 = out1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push0(input int c, input logic v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        q0.push_back(e);
    endtask

    // Drive in0 (at a negedge) and queue the accepted change 6 edges later.
    task automatic level0(input logic v);
        in0 = v;
        push0(cyc + 6, v);
        tick(8);
    endtask

    initial begin
        int c0;
        resetn = 1'b0;
        in0    = 1'b0;
        in1    = 1'b0;
        tick(2);
        chk("reset_out", int'(out0), 0);
        chk("reset_pending", int'(pend0), 0);
        chk("reset_out1", int'(out1), 0);
        chk("reset_pending1", int'(pend1), 0);
        resetn = 1'b1;
        tick(2);

        // Clean rise: pending high after edges 3..5, out rises on edge 6.
        in0 = 1'b1;
        push0(cyc + 6, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            chk($sformatf("rise_pending_e%0d", i), int'(pend0), (i >= 3 && i <= 5) ? 1 : 0);
        end
        tick(1);

        // Clean fall from 1, no intermediate toggle.
        level0(1'b0);

        // Three-cycle pulse: qualifies to count 3 then glitches back.
        in0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (i == 3) in0 = 1'b0;
            chk($sformatf("pulse_pending_e%0d", i), int'(pend0), (i >= 3 && i <= 5) ? 1 : 0);
        end
        chk("pulse_out", int'(out0), 0);

        // Bounce 1,0,1,0,1 then steady 1: rise 6 edges after the last 0->1.
        in0 = 1'b1; tick(1);
        in0 = 1'b0; tick(1);
        in0 = 1'b1; tick(1);
        in0 = 1'b0; tick(1);
        in0 = 1'b1;
        push0(cyc + 6, 1'b1);
        tick(9);
        chk("bounce_out", int'(out0), 1);
        level0(1'b0);

        // Reset during qualification (counter = 2) discards the change.
        in0 = 1'b1;
        tick(4);
        chk("midq_pending_before", int'(pend0), 1);
        resetn = 1'b0;
        #1;
        chk("midq_pending_async", int'(pend0), 0);
        chk("midq_out_async", int'(out0), 0);
        tick(2);
        resetn = 1'b1;
        push0(cyc + 6, 1'b1);
        tick(5);
        chk("postreset_out_e5", int'(out0), 0);
        tick(3);
        level0(1'b0);

        // DEBOUNCE_CYCLES = 1: rise after 3 edges, pending never set.
        in1 = 1'b1;
        begin
            exp_t e;
            e.cyc = cyc + 3;
            e.val = 1'b1;
            q1.push_back(e);
        end
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk($sformatf("dc1_pending_e%0d", i), int'(pend1), 0);
        end
        c0 = cyc;
        tick(4);
        chk("dc1_out", int'(out1), 1);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        if (cyc - c0 > 100000) chk("cycle_budget", cyc - c0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
